// File: rtl/video_timing_controller_if.sv
// Signal bundle between the raster timing generator, the system controller and the
// pixel pipeline. The master side is the timing generator itself.
interface video_timing_controller_if;
    logic        i_video_enable;
    logic        o_video_switch_allowed;
    logic        o_running;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_de;
    logic [10:0] o_x;
    logic [10:0] o_y;
    logic        o_line_start;
    logic        o_frame_start;

    modport master (
        input  i_video_enable,
        output o_video_switch_allowed, o_running, o_hsync, o_vsync, o_de,
        output o_x, o_y, o_line_start, o_frame_start
    );

    modport slave (
        output i_video_enable,
        input  o_video_switch_allowed, o_running, o_hsync, o_vsync, o_de,
        input  o_x, o_y, o_line_start, o_frame_start
    );
endinterface

// File: rtl/video_timing_controller.sv
// Free-running raster timing generator: starts on enable, stops only at a frame
// boundary, and flags vertical blanking as the safe window for mode switches.
module video_timing_controller #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 48,
    parameter int unsigned H_BP     = 40,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 13,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 29,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic                              i_master_clk,
    input  logic                              i_reset_n,
    video_timing_controller_if.master         vif
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

    state_e      state_q, state_d;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        switch_allowed_q, switch_allowed_d;
    logic        running_q, running_d;

    logic active;
    logic last_h;
    logic last_v;
    logic hs_act;
    logic vs_act;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        active  = (state_q != IDLE);
        last_h  = (h_q == H_LAST);
        last_v  = (v_q == V_LAST);

        case (state_q)
            IDLE:     if (vif.i_video_enable) state_d = RUN;
            RUN:      if (!vif.i_video_enable) state_d = STOPPING;
            STOPPING: begin
                if (vif.i_video_enable)    state_d = RUN;
                else if (last_h && last_v) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        // Stopping only happens at the last position, where the wrap already yields (0,0).
        if (active) begin
            if (last_h) begin
                h_d = '0;
                v_d = last_v ? '0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end

        hs_act           = active && (h_q >= HS_START) && (h_q < HS_END);
        vs_act           = active && (v_q >= VS_START) && (v_q < VS_END);
        de_d             = active && (h_q < H_ACT) && (v_q < V_ACT);
        hsync_d          = hs_act ? SYNC_POL : ~SYNC_POL;
        vsync_d          = vs_act ? SYNC_POL : ~SYNC_POL;
        x_d              = de_d ? h_q : '0;
        y_d              = de_d ? v_q : '0;
        line_start_d     = active && (h_q == '0);
        frame_start_d    = active && (h_q == '0) && (v_q == '0);
        switch_allowed_d = !active || (v_q >= V_ACT);
        running_d        = active;
    end

    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q          <= IDLE;
            h_q              <= '0;
            v_q              <= '0;
            hsync_q          <= ~SYNC_POL;
            vsync_q          <= ~SYNC_POL;
            de_q             <= 1'b0;
            x_q              <= '0;
            y_q              <= '0;
            line_start_q     <= 1'b0;
            frame_start_q    <= 1'b0;
            switch_allowed_q <= 1'b1;
            running_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            h_q              <= h_d;
            v_q              <= v_d;
            hsync_q          <= hsync_d;
            vsync_q          <= vsync_d;
            de_q             <= de_d;
            x_q              <= x_d;
            y_q              <= y_d;
            line_start_q     <= line_start_d;
            frame_start_q    <= frame_start_d;
            switch_allowed_q <= switch_allowed_d;
            running_q        <= running_d;
        end
    end

    assign vif.o_hsync                = hsync_q;
    assign vif.o_vsync                = vsync_q;
    assign vif.o_de                   = de_q;
    assign vif.o_x                    = x_q;
    assign vif.o_y                    = y_q;
    assign vif.o_line_start           = line_start_q;
    assign vif.o_frame_start          = frame_start_q;
    assign vif.o_video_switch_allowed = switch_allowed_q;
    assign vif.o_running              = running_q;
endmodule

// File: tb/tb_video_timing_controller.sv
// Bench for video_timing_controller on a shrunken raster (15 x 11) so whole frames fit
// in a short run; a linear-position reference model predicts every output each clock.
module tb_video_timing_controller;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [28:0] IDLE_OUT = {7'b1100010, 22'd0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_timing_controller_if vif();

    video_timing_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .i_master_clk(clk),
        .i_reset_n   (rst_n),
        .vif         (vif)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: running flag plus linear position within the frame.
    bit          m_run;
    int          m_p;
    bit          m_en_prev;
    logic [28:0] exp_q;

    int cyc, last_fs, period, fs_cnt, de_cnt, ls_cnt, hs_cnt, vs_cnt, sw_cnt;

    typedef struct {
        bit          en;
        logic [28:0] exp;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [28:0] pack_dut();
        return {vif.o_hsync, vif.o_vsync, vif.o_de, vif.o_line_start, vif.o_frame_start,
                vif.o_video_switch_allowed, vif.o_running, vif.o_x, vif.o_y};
    endfunction

    function automatic logic [28:0] ref_out(bit run, int p);
        int h, v;
        logic de, hs_act, vs_act;
        logic [10:0] x, y;
        if (!run) return IDLE_OUT;
        h = p % HT;
        v = p / HT;
        de     = (h < HA) && (v < VA);
        hs_act = (h >= HA + HF) && (h < HA + HF + HS);
        vs_act = (v >= VA + VF) && (v < VA + VF + VS);
        x = de ? 11'(h) : 11'd0;
        y = de ? 11'(v) : 11'd0;
        return {~hs_act, ~vs_act, de, (h == 0), (p == 0), (v >= VA), 1'b1, x, y};
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_p = 0;
        m_en_prev = 1'b0;
    endtask

    // A frame ends in idle only if enable was low on its last clock and the one before.
    task automatic model_edge(bit en);
        exp_q = ref_out(m_run, m_p);
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_p = 0;
            end
        end else if (m_p == FRAME - 1) begin
            m_p = 0;
            if (!en && !m_en_prev) m_run = 1'b0;
        end else begin
            m_p++;
        end
        m_en_prev = en;
    endtask

    task automatic check(string name, logic [28:0] act, logic [28:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; last_fs = -1; period = 0; fs_cnt = 0; de_cnt = 0;
        ls_cnt = 0; hs_cnt = 0; vs_cnt = 0; sw_cnt = 0;
    endtask

    task automatic step(bit en);
        vif.i_video_enable = en;
        @(posedge clk);
        model_edge(en);
        @(negedge clk);
        check("model", pack_dut(), exp_q);
        cyc++;
        if (vif.o_de) de_cnt++;
        if (vif.o_line_start) ls_cnt++;
        if (!vif.o_hsync) hs_cnt++;
        if (!vif.o_vsync) vs_cnt++;
        if (vif.o_video_switch_allowed) sw_cnt++;
        if (vif.o_frame_start) begin
            if (last_fs >= 0) period = cyc - last_fs;
            last_fs = cyc;
            fs_cnt++;
        end
    endtask

    task automatic steps(bit en, int n);
        for (int i = 0; i < n; i++) step(en);
    endtask

    initial begin
        tbl[0] = '{1'b0, IDLE_OUT};
        tbl[1] = '{1'b1, IDLE_OUT};
        tbl[2] = '{1'b0, {7'b1111101, 11'd0, 11'd0}};
        tbl[3] = '{1'b0, {7'b1110001, 11'd1, 11'd0}};
        tbl[4] = '{1'b1, {7'b1110001, 11'd2, 11'd0}};
        tbl[5] = '{1'b1, {7'b1110001, 11'd3, 11'd0}};

        vif.i_video_enable = 1'b0;
        model_reset();
        clr_stats();
        repeat (2) @(negedge clk);
        check("reset_state", pack_dut(), IDLE_OUT);
        rst_n = 1'b1;

        // Start sequence from idle, including a one-clock enable dip that must not restart.
        foreach (tbl[i]) begin
            step(tbl[i].en);
            check($sformatf("table[%0d]", i), pack_dut(), tbl[i].exp);
        end

        // Asynchronous reset mid-frame.
        steps(1'b1, 3 * HT + 4);
        #2 rst_n = 1'b0;
        #1 check("async_reset", pack_dut(), IDLE_OUT);
        model_reset();
        vif.i_video_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", pack_dut(), IDLE_OUT);
        rst_n = 1'b1;
        steps(1'b0, 3);

        // One full frame of statistics, then frame-start period.
        step(1'b1);
        clr_stats();
        steps(1'b1, FRAME);
        check_int("de_per_frame", de_cnt, HA * VA);
        check_int("frame_starts", fs_cnt, 1);
        check_int("line_starts", ls_cnt, VT);
        check_int("hsync_clks", hs_cnt, HS * VT);
        check_int("vsync_clks", vs_cnt, VS * HT);
        check_int("switch_clks", sw_cnt, (VT - VA) * HT);
        steps(1'b1, FRAME);
        check_int("fs_period", period, FRAME);

        // Drop enable at v=2: raster runs out to the last position, then idle.
        steps(1'b1, 2 * HT);
        clr_stats();
        begin
            int n = 0;
            do begin
                step(1'b0);
                n++;
            end while (vif.o_running && n < 2 * FRAME);
            check_int("stop_latency", n, FRAME - 2 * HT + 1);
        end
        clr_stats();
        steps(1'b0, 2 * FRAME);
        check_int("no_fs_after_stop", fs_cnt, 0);

        // Re-raise before the frame ends: no gap in the raster.
        clr_stats();
        step(1'b1);
        steps(1'b1, 2 * HT);
        steps(1'b0, 3 * HT);
        steps(1'b1, FRAME);
        check_int("reraise_fs_cnt", fs_cnt, 2);
        check_int("reraise_period", period, FRAME);
        steps(1'b0, 2 * FRAME + 2);

        // Single-clock enable pulse from idle gives exactly one frame.
        clr_stats();
        step(1'b1);
        steps(1'b0, 3 * FRAME);
        check_int("pulse_fs_cnt", fs_cnt, 1);
        check_int("pulse_de_cnt", de_cnt, HA * VA);
        check_int("pulse_running", int'(vif.o_running), 0);

        // Random enable levels, mixing short glitches with long holds.
        begin
            int total = 0;
            while (total < 6000) begin
                bit en = 1'($urandom_range(0, 1));
                int len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                      : $urandom_range(1, 2 * FRAME);
                steps(en, len);
                total += len;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
